// File: rtl/result_demux_if.sv
// Handshake bundle for the 1-to-2 result demultiplexer: one upstream stream, two consumer streams.
interface result_demux_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out0_valid;
   logic [WIDTH-1:0] out0_data;
   logic             out0_ready;
   logic             out1_valid;
   logic [WIDTH-1:0] out1_data;
   logic             out1_ready;

   modport master (
      output in_valid, in_sel, in_data, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

   modport slave (
      input  in_valid, in_sel, in_data, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data
   );
endinterface

// File: rtl/result_demux_1to2.sv
// Registered 1-to-2 result demultiplexer. Each output owns a small FIFO so a
// stalled consumer only back-pressures beats addressed to it.
module result_demux_1to2 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   result_demux_if.slave  bus
);
   localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic [PW-1:0]    wr_ptr_q [2];
   logic [PW-1:0]    wr_ptr_d [2];
   logic [PW-1:0]    rd_ptr_q [2];
   logic [PW-1:0]    rd_ptr_d [2];
   logic [PW:0]      count_q  [2];
   logic [PW:0]      count_d  [2];
   logic [1:0]       full;
   logic [1:0]       empty;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       out_ready;

   assign out_ready = {bus.out1_ready, bus.out0_ready};

   // No pass-through when full: in_ready ignores a same-cycle pop.
   assign bus.in_ready = bus.in_sel ? ~full[1] : ~full[0];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i]     = (count_q[i] == FULL_CNT);
         empty[i]    = (count_q[i] == '0);
         push[i]     = bus.in_valid & (bus.in_sel == 1'(i)) & ~full[i];
         pop[i]      = ~empty[i] & out_ready[i];
         wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
         rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
         case ({push[i], pop[i]})
            2'b10:   count_d[i] = count_q[i] + (PW+1)'(1);
            2'b01:   count_d[i] = count_q[i] - (PW+1)'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
            if (push[i]) begin
               mem_q[i][wr_ptr_q[i]] <= bus.in_data;
            end
         end
      end
   end

   assign bus.out0_valid = ~empty[0];
   assign bus.out0_data  = mem_q[0][rd_ptr_q[0]];
   assign bus.out1_valid = ~empty[1];
   assign bus.out1_data  = mem_q[1][rd_ptr_q[1]];

   a_sel_known : assert property (@(posedge clk) disable iff (rst)
      bus.in_valid |-> !$isunknown(bus.in_sel));
endmodule
